linebuffer_pp: RTL
==================

# linebuffer_pp

Parametrised ping-pong sprite line buffer for the video_sync path. The sprite renderer writes palette and colour-index pixels into one bank while the display side streams the other bank out. The display side optionally restores each read location to the backdrop value. Banks exchange on a per-line swap strobe. Width, depth and backdrop value are parameters; colour index 0 is treated as transparent.

## Interface
Parameters:
- CW, 4, colour-index width.
- PW, 8, palette width; pixel word is {palette, colour} = PW+CW bits.
- AW, 8, address width of each bank.
- DEPTH, 192, valid pixels per line; DEPTH <= 2^AW.
- BACKDROP, all ones (PW+CW bits), clear/out-of-range value.

Ports:
- CLK  in  1  single clock, all logic rising-edge.
- RST  in  1  reset, asynchronous, active-high.
- PAL_LOAD  in  1  latch WR_PAL into palette register.
- WR_PAL  in  PW  sprite palette.
- WR_LOAD  in  1  load write pointer from WR_ADDR.
- WR_ADDR  in  AW  write start address.
- WR_EN  in  1  write one pixel at current write address, then increment.
- WR_COLOR  in  CW  colour index of pixel.
- SWAP  in  1  end-of-line strobe: exchange banks.
- RD_EN  in  1  read next pixel from read bank.
- RD_DATA  out  PW+CW  pixel {palette, colour}.
- RD_VALID  out  1  RD_DATA updated this cycle.
- WR_OVF  out  1  sticky: a pixel was dropped at address >= DEPTH since last SWAP.

## Operation
- Two banks of 2^AW x (PW+CW). SEL selects the write bank; the read bank is !SEL. After reset SEL=0.
- Palette register updates on PAL_LOAD. A same-cycle WR_EN uses the old palette.
- Write address:
  - WA = WR_LOAD ? WR_ADDR : WPTR.
  - When WR_EN: WPTR <= WA+1, wrapping mod 2^AW.
  - When WR_LOAD without WR_EN: WPTR <= WR_ADDR.
- Write data:
  - If WR_COLOR == 0, the pixel is transparent: no RAM write, but the pointer still advances.
  - If WA >= DEPTH, the write is suppressed and WR_OVF is set.
  - Otherwise the bank is written with {PAL, WR_COLOR}.
- Read:
  - RD_EN with RPTR < DEPTH reads the read bank at RPTR and increments RPTR.
  - RD_EN with RPTR >= DEPTH returns BACKDROP; RPTR holds.
- SWAP:
  - SEL toggles; WPTR, RPTR and WR_OVF clear to 0.
  - A same-cycle WR_EN completes into the pre-swap write bank.
  - A same-cycle RD_EN is ignored (RD_VALID=0 next cycle).
- Reset mid-line: all registers return to reset values immediately. RAM contents are not reset.

## Timing
- Reset values: RD_DATA=0, RD_VALID=0, WR_OVF=0, SEL=0, WPTR=0, RPTR=0, PAL=0.
- Write: WR_EN in cycle n; the RAM holds the pixel from edge n+1. The read bank is never the write bank, so there are no collisions.
- Read latency 1: RD_EN in cycle n gives RD_DATA/RD_VALID at the edge ending cycle n. The output is registered and holds until the next RD_EN.
- Back-to-back RD_EN every cycle is supported, 1 pixel/clock.
- WR_OVF asserts in the cycle after the dropped write and holds until SWAP or RST.

## Configuration
- LB_AUTOCLEAR_EN defined:
  - Each in-range read also writes BACKDROP to the same address of the read bank one cycle later, through the read bank's second port.
  - After a full DEPTH readout, the bank is all BACKDROP and ready for the next line.
  - A SWAP landing on the clear cycle still completes the clear to the pre-swap read bank.
- Undefined: reads are non-destructive and the bank retains its contents; the renderer owns clearing.

## Test plan
- Reset, SWAP, WR_LOAD addr 5 + PAL 0x3A + WR_EN colours 1,0,7, SWAP, 8 x RD_EN -> RD_DATA at addr 5 = 0x3A1, addr 6 unchanged (transparent), addr 7 = 0x3A7, each RD_VALID one cycle after RD_EN.
- With LB_AUTOCLEAR_EN: after full readout of bank, SWAP twice, read again -> all 192 pixels = 0xFFF.
- WR_LOAD addr 190 + 4 opaque WR_EN -> addrs 190,191 written; WR_OVF=1 from the 4th cycle; SWAP -> WR_OVF=0.
- 200 consecutive RD_EN -> pixels 192..199 return 0xFFF, RPTR stays 192.
- SWAP same cycle as WR_EN colour 9 and RD_EN -> pixel lands in old write bank; RD_VALID=0 next cycle; RPTR=0.
- Assert RST mid-line during streaming -> RD_VALID, RD_DATA, WR_OVF drop to 0 asynchronously; next read comes from bank 1 at addr 0.

Source files
------------

// File: rtl/linebuffer_pp.sv
// linebuffer_pp: ping-pong sprite line buffer. The renderer fills one bank while
// the display streams the other; banks exchange on SWAP. Transparent pixels
// (colour 0) advance the write pointer without touching the RAM.
// Optional feature macro: LB_AUTOCLEAR_EN -- every in-range read restores the
// location to BACKDROP one cycle later, so a fully read bank comes back clean.
module linebuffer_pp #(
  parameter int unsigned CW    = 4,
  parameter int unsigned PW    = 8,
  parameter int unsigned AW    = 8,
  parameter int unsigned DEPTH = 192,
  parameter logic [PW+CW-1:0] BACKDROP = '1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              PAL_LOAD,
  input  logic [PW-1:0]     WR_PAL,
  input  logic              WR_LOAD,
  input  logic [AW-1:0]     WR_ADDR,
  input  logic              WR_EN,
  input  logic [CW-1:0]     WR_COLOR,
  input  logic              SWAP,
  input  logic              RD_EN,
  output logic [PW+CW-1:0]  RD_DATA,
  output logic              RD_VALID,
  output logic              WR_OVF
);

  localparam int unsigned DW     = PW + CW;
  localparam int unsigned NWORDS = 1 << AW;
  localparam int unsigned RW     = AW + 1;  // one extra bit so RPTR can rest at DEPTH == 2^AW

  logic [DW-1:0] mem [2][NWORDS];

  logic          sel;
  logic [AW-1:0] wptr;
  logic [RW-1:0] rptr;
  logic [PW-1:0] pal;

  logic [AW-1:0] wa;
  logic          wr_opaque;
  logic          wa_in_range;
  logic          wr_do;
  logic          ovf_set;
  logic          rd_do;
  logic          rd_in_range;

  // Write address select, write/drop qualification and read qualification
  always_comb begin
    wa          = WR_LOAD ? WR_ADDR : wptr;
    wr_opaque   = (WR_COLOR != '0);
    wa_in_range = (32'(wa) < DEPTH);
    wr_do       = WR_EN && wr_opaque && wa_in_range;
    ovf_set     = WR_EN && wr_opaque && !wa_in_range;
    rd_do       = RD_EN && !SWAP;
    rd_in_range = (32'(rptr) < DEPTH);
  end

  // Write side: palette, bank select, write pointer and sticky overflow flag
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pal    <= '0;
      sel    <= 1'b0;
      wptr   <= '0;
      WR_OVF <= 1'b0;
    end else begin
      if (PAL_LOAD) pal <= WR_PAL;
      if (SWAP) begin
        sel    <= ~sel;
        wptr   <= '0;
        WR_OVF <= 1'b0;
      end else begin
        if (WR_EN)        wptr <= wa + AW'(1);
        else if (WR_LOAD) wptr <= WR_ADDR;
        if (ovf_set) WR_OVF <= 1'b1;
      end
    end
  end

  // Read side: registered pixel output, valid strobe and read pointer
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      RD_DATA  <= '0;
      RD_VALID <= 1'b0;
      rptr     <= '0;
    end else begin
      RD_VALID <= rd_do;
      if (rd_do) begin
        if (rd_in_range) begin
          RD_DATA <= mem[~sel][rptr[AW-1:0]];
          rptr    <= rptr + RW'(1);
        end else begin
          RD_DATA <= BACKDROP;
        end
      end
      if (SWAP) rptr <= '0;
    end
  end

`ifdef LB_AUTOCLEAR_EN
  logic          clr_pend;
  logic          clr_bank;
  logic [AW-1:0] clr_addr;

  // Remember the location just read so it is restored on the following cycle
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      clr_pend <= 1'b0;
      clr_bank <= 1'b0;
      clr_addr <= '0;
    end else begin
      clr_pend <= rd_do && rd_in_range;
      clr_bank <= ~sel;
      clr_addr <= rptr[AW-1:0];
    end
  end

  // Bank RAM: renderer port on the write bank, clear port on the read bank
  always_ff @(posedge CLK) begin
    if (wr_do)    mem[sel][wa]            <= {pal, WR_COLOR};
    if (clr_pend) mem[clr_bank][clr_addr] <= BACKDROP;
  end
`else
  // Bank RAM: renderer port on the write bank only
  always_ff @(posedge CLK) begin
    if (wr_do) mem[sel][wa] <= {pal, WR_COLOR};
  end
`endif

endmodule
